commit_trace_fifo: RTL
======================

Name: commit_trace_fifo

Overview:
- Sits directly downstream of the single-cycle RISC-V CPU's retire point.
- Captures one record per retired instruction: PC, destination register and write data.
- Buffers records in a FIFO and streams them to a valid/ready consumer (trace dumper or checker).
- Detects end-of-program, when a retired instruction word is all zeros, and drains the FIFO before asserting halt.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the retired and dropped counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-low reset.
- commit_valid_i  in  1  an instruction retires this cycle.
- commit_pc_i  in  32  PC of the retiring instruction.
- commit_inst_i  in  32  instruction word of the retiring instruction.
- commit_rd_i  in  5  destination register index.
- commit_rd_we_i  in  1  register write enable.
- commit_rd_data_i  in  32  value written to rd.
- trace_valid_o  out  1  head record is available.
- trace_ready_i  in  1  consumer accepts the head record.
- trace_pc_o  out  32  head record PC.
- trace_rd_o  out  5  head record rd.
- trace_rd_we_o  out  1  head record write enable.
- trace_data_o  out  32  head record write data.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- retired_cnt_o  out  CNT_W  records accepted since reset.
- drop_cnt_o  out  CNT_W  records dropped because the FIFO was full.
- overflow_o  out  1  sticky; at least one record dropped.
- halt_o  out  1  program ended and FIFO fully drained.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FIFO empty, level_o=0, trace_valid_o=0.
  - Both counters 0, overflow_o=0, halt_o=0, state RUN.
  - Trace data outputs read 0.
- Push: commit_valid_i=1, state RUN and commit_inst_i!=0.
  - Record stored as {pc, rd, rd_we & (rd!=0), rd_data}.
  - A write to x0 is stored with rd_we=0 and data 0.
- Pop: trace_valid_o & trace_ready_i.
  - trace_* outputs show the head entry combinationally from the storage array (show-ahead).
  - Latency from push edge to trace_valid_o=1 is 1 cycle when the FIFO was empty.
- Full:
  - A push while full with no pop is dropped.
  - drop_cnt_o increments, saturating at all-ones; overflow_o sets and stays set until reset.
  - A push and pop in the same cycle while full are both accepted; level unchanged.
- Empty:
  - trace_valid_o=0; trace_ready_i is ignored.
  - A simultaneous push is accepted; the record appears the next cycle.
- retired_cnt_o increments, saturating, on each accepted push only.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- State machine:
  - RUN -> DRAIN on commit_valid_i with commit_inst_i==0. The zero instruction is not recorded.
  - DRAIN: all commits are ignored; pops continue. DRAIN -> HALTED when level==0, evaluated after that cycle's pop.
  - HALTED: halt_o=1; all commits ignored; only reset exits.
- Reset mid-operation: contents discarded immediately; no partial record is emitted.

Optional Feature:
- Macro: TRACE_BACKPRESSURE_EN.
- Defined:
  - Adds output port commit_stall_o (1 bit) = full & ~(trace_valid_o & trace_ready_i).
  - The CPU must hold its retire while stalled.
  - A push while commit_stall_o=1 is held, not dropped; drop_cnt_o stays 0 and overflow_o stays 0.
- Undefined:
  - No port is added; drop behaviour applies as above.

Test Plan:
- Reset, then 3 commits with trace_ready_i=1:
  - Commits: pc 0/4/8, rd 5/6/7, data 10/20/30.
  - Required: three records appear one cycle after each push, in order; retired_cnt_o=3.
- Commit with rd=0, we=1, data 0x55:
  - Required: record shows trace_rd_we_o=0 and trace_data_o=0.
- DEPTH=16, trace_ready_i=0, 18 commits:
  - Required: level_o=16, drop_cnt_o=2, overflow_o=1.
  - Then raise ready: exactly 16 records (pc 0..60) drain in order.
- Full FIFO, one commit plus ready=1 in the same cycle:
  - Required: level stays 16, no drop, and the new record is last out.
- 4 commits, then commit_inst_i=0, with ready held 0 for 5 cycles:
  - Required: halt_o=0 while level=4; later commits ignored.
  - After ready is raised and 4 pops complete: halt_o=1 on the following edge.
- With TRACE_BACKPRESSURE_EN, 17 commits with ready=0:
  - Required: commit_stall_o=1 at level 16; the 17th record is held, not dropped; drop_cnt_o=0.
  - One pop accepts the held record.
- Assert rst_i=0 mid-drain with level=5:
  - Required: level_o, trace_valid_o and halt_o all go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//   Captures one trace record per retired instruction of a single-cycle
//   RISC-V core and streams the records to a valid/ready consumer through
//   a show-ahead FIFO. A retired all-zero instruction word marks the end of
//   the program. After that the FIFO drains and halt_o is raised.
//
// Optional feature (macro TRACE_BACKPRESSURE_EN):
//   When the macro is defined, the block adds the output commit_stall_o.
//   A commit that arrives while the FIFO is full is then held back instead
//   of being dropped.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   commit_*_i                retire-point record (valid, pc, inst, rd, we, data)
//   commit_stall_o            (TRACE_BACKPRESSURE_EN only) core must hold retire
//   trace_valid_o/ready_i     head-record handshake
//   trace_pc/rd/rd_we/data_o  head record, reads 0 while the FIFO is empty
//   level_o                   occupancy, 0..DEPTH
//   retired_cnt_o             accepted records, saturating
//   drop_cnt_o                records lost to a full FIFO, saturating
//   overflow_o                sticky: at least one record dropped
//   halt_o                    program ended and FIFO drained
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   commit_valid_i,
  input  logic [31:0]            commit_pc_i,
  input  logic [31:0]            commit_inst_i,
  input  logic [4:0]             commit_rd_i,
  input  logic                   commit_rd_we_i,
  input  logic [31:0]            commit_rd_data_i,
`ifdef TRACE_BACKPRESSURE_EN
  output logic                   commit_stall_o,
`endif
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [31:0]            trace_pc_o,
  output logic [4:0]             trace_rd_o,
  output logic                   trace_rd_we_o,
  output logic [31:0]            trace_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [CNT_W-1:0]       retired_cnt_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  output logic                   overflow_o,
  output logic                   halt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = 70;  // {pc[69:38], rd[37:33], we[32], data[31:0]}
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [LW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] retired_q, drop_q;
  logic             overflow_q;

  logic             full, empty, pop, push_req, push, drop, end_seen;
  logic             wr_we;
  logic [31:0]      wr_data;
  logic [RW-1:0]    wr_rec, rd_rec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full     = (count_q == FULL_LVL);
  assign empty    = (count_q == '0);
  assign pop      = ~empty & trace_ready_i;
  assign push_req = commit_valid_i & (state_q == RUN) & (commit_inst_i != '0);
  assign end_seen = commit_valid_i & (state_q == RUN) & (commit_inst_i == '0);

`ifdef TRACE_BACKPRESSURE_EN
  // A full FIFO only stalls the core if no slot is freed this cycle.
  assign commit_stall_o = full & ~pop;
  assign drop           = 1'b0;
`else
  assign drop           = push_req & full & ~pop;
`endif
  // When the FIFO is full, a push is still accepted if the head leaves in the same cycle.
  assign push    = push_req & (~full | pop);
  assign count_d = count_q + LW'(push) - LW'(pop);

  // A write to x0 has no architectural effect, so it is recorded as a non-write.
  assign wr_we   = commit_rd_we_i & (commit_rd_i != '0);
  assign wr_data = (commit_rd_we_i && (commit_rd_i == '0)) ? 32'd0 : commit_rd_data_i;
  assign wr_rec  = {commit_pc_i, commit_rd_i, wr_we, wr_data};

  // Show-ahead read. The outputs are forced to 0 while the FIFO is empty, so stale entries never appear.
  assign rd_rec        = empty ? '0 : mem_q[head_q];
  assign trace_valid_o = ~empty;
  assign trace_pc_o    = rd_rec[69:38];
  assign trace_rd_o    = rd_rec[37:33];
  assign trace_rd_we_o = rd_rec[32];
  assign trace_data_o  = rd_rec[31:0];

  assign level_o       = count_q;
  assign retired_cnt_o = retired_q;
  assign drop_cnt_o    = drop_q;
  assign overflow_o    = overflow_q;
  assign halt_o        = (state_q == HALTED);

  // The drain check uses the post-pop level, so HALTED follows the last pop on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (end_seen) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      retired_q  <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        tail_q    <= tail_q + AW'(1);
        retired_q <= sat_inc(retired_q);
      end
      if (pop) head_q <= head_q + AW'(1);
      if (drop) begin
        drop_q     <= sat_inc(drop_q);
        overflow_q <= 1'b1;
      end
    end
  end

  // Record storage is not reset. Entries are valid only between head and tail.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[tail_q] <= wr_rec;
  end

endmodule
